mult_err_accum: RTL and testbench

MULT_ERR_ACCUM -- requirements
Module: mult_err_accum

---
 rtl/mult_err_accum.sv | 163 ++++++++++++++++
 tb/tb_mult_err_accum.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_err_accum.sv
// Error-statistics accumulator for an approximate 8x8 multiplier.
// Optional max-error tracking is enabled by defining MULT_ERR_MAX_EN.
module mult_err_accum #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic [15:0]      Y,
   output logic             busy,
   output logic             done,
   output logic [31:0]      sum_ed,
   output logic [CNT_W-1:0] err_cnt,
   output logic [15:0]      max_ed
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drn_q, drn_d;

   logic             s1_vld_q;
   logic [7:0]       s1_a_q, s1_b_q;
   logic [15:0]      s1_y_q;

   logic [31:0]      sum_q, sum_d;
   logic [CNT_W-1:0] err_q, err_d;

   logic             accept;
   logic             clear;
   logic [15:0]      exact;
   logic [15:0]      ed;
   logic [32:0]      sum_ext;

   assign in_ready = (state_q == RUN) && (cnt_q < num_q);
   assign accept   = in_valid && in_ready;
   assign clear    = start && ((state_q == IDLE) || (state_q == DONE));

   assign exact   = 16'(s1_a_q) * 16'(s1_b_q);
   assign ed      = (exact >= s1_y_q) ? (exact - s1_y_q) : (s1_y_q - exact);
   assign sum_ext = {1'b0, sum_q} + {17'b0, ed};

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      drn_d   = drn_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               num_d   = num_samples;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept) cnt_d = cnt_q + CNT_W'(1);
            // Also covers num_samples == 0 on the first RUN cycle.
            if (cnt_d >= num_q) begin
               state_d = DRAIN;
               drn_d   = 1'b0;
            end
         end
         DRAIN: begin
            drn_d = 1'b1;
            if (drn_q) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         num_q   <= '0;
         cnt_q   <= '0;
         drn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         drn_q   <= drn_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
         s1_y_q   <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_a_q <= a;
            s1_b_q <= b;
            s1_y_q <= Y;
         end
      end
   end

   always_comb begin
      sum_d = sum_q;
      err_d = err_q;
      if (clear) begin
         sum_d = '0;
         err_d = '0;
      end else if (s1_vld_q) begin
         sum_d = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
         if ((ed != 16'd0) && (err_q != {CNT_W{1'b1}}))
            err_d = err_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         err_q <= '0;
      end else begin
         sum_q <= sum_d;
         err_q <= err_d;
      end
   end

`ifdef MULT_ERR_MAX_EN
   logic [15:0] max_q, max_d;

   always_comb begin
      max_d = max_q;
      if (clear)
         max_d = '0;
      else if (s1_vld_q && (ed > max_q))
         max_d = ed;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) max_q <= '0;
      else        max_q <= max_d;
   end

   assign max_ed = max_q;
`else
   assign max_ed = 16'd0;
`endif

   assign busy    = (state_q == RUN) || (state_q == DRAIN);
   assign done    = (state_q == DONE);
   assign sum_ed  = sum_q;
   assign err_cnt = err_q;

endmodule

// File: tb/tb_mult_err_accum.sv
// Directed bench for mult_err_accum with a result scoreboard.
// Define MULT_ERR_MAX_EN here too when building the DUT with it.
module tb_mult_err_accum;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] num_samples;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a, b;
   logic [15:0] Y;
   logic        busy, done;
   logic [31:0] sum_ed;
   logic [15:0] err_cnt;
   logic [15:0] max_ed;

   mult_err_accum #(.CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .num_samples (num_samples),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .Y           (Y),
      .busy        (busy),
      .done        (done),
      .sum_ed      (sum_ed),
      .err_cnt     (err_cnt),
      .max_ed      (max_ed)
   );

   typedef struct {
      logic [31:0] s;
      logic [15:0] c;
      logic [15:0] m;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  sa[8];
   logic [7:0]  sbv[8];
   logic [15:0] sy[8];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          acc_cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic ld(input int i, input int x, input int y, input int p);
      sa[i]  = 8'(x);
      sbv[i] = 8'(y);
      sy[i]  = 16'(p);
   endtask

   task automatic pulse_start(input int n);
      start       = 1'b1;
      num_samples = 16'(n);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int n, input bit tog, input bit mid);
      int  i = 0;
      int  g = 0;
      bit  acc;
      while (i < n && g < 200) begin
         in_valid = tog ? ((g % 2) == 0) : 1'b1;
         a = sa[i];
         b = sbv[i];
         Y = sy[i];
         if (mid && g == 2) begin
            start       = 1'b1;
            num_samples = 16'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) acc_cyc = cyc;
         @(posedge clk); #1;
         if (acc) i++;
         g++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("accepted", 32'(i), 32'(n));
   endtask

   task automatic finish_run(input int n, input string tag);
      exp_t        e;
      exp_t        got_e;
      logic [15:0] ex, d;
      bit          got = 0;
      bit          rdy = 0;
      int          dcyc = 0;
      e.s = 0;
      e.c = 0;
      e.m = 0;
      for (int i = 0; i < n; i++) begin
         ex = 16'(sa[i]) * 16'(sbv[i]);
         d  = (ex >= sy[i]) ? ex - sy[i] : sy[i] - ex;
         e.s = e.s + 32'(d);
         if (d != 0) e.c = e.c + 16'd1;
`ifdef MULT_ERR_MAX_EN
         if (d > e.m) e.m = d;
`endif
      end
      sb.push_back(e);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready) rdy = 1;
         if (done) begin
            got  = 1;
            dcyc = cyc;
            break;
         end
      end
      check({tag, "_done"}, 32'(got), 32'd1);
      check({tag, "_rdy_low"}, 32'(rdy), 32'd0);
      if (n > 0) check({tag, "_lat"}, 32'(dcyc - acc_cyc), 32'd3);
      got_e = sb.pop_front();
      check({tag, "_sum"}, sum_ed, got_e.s);
      check({tag, "_cnt"}, 32'(err_cnt), 32'(got_e.c));
      check({tag, "_max"}, 32'(max_ed), 32'(got_e.m));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic load_err_set();
      ld(0, 15, 15, 209);
      ld(1, 10, 10, 100);
      ld(2, 200, 3, 590);
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      num_samples = '0;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      Y           = '0;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rdy", 32'(in_ready), 32'd0);
      check("rst_sum", sum_ed, 32'd0);
      check("rst_cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      ld(0, 3, 5, 15);
      ld(1, 255, 255, 65025);
      ld(2, 0, 9, 0);
      ld(3, 16, 16, 256);
      pulse_start(4);
      feed(4, 1'b0, 1'b0);
      finish_run(4, "exact");

      load_err_set();
      pulse_start(3);
      feed(3, 1'b0, 1'b0);
      finish_run(3, "err");

      ld(0, 7, 9, 60);
      ld(1, 20, 20, 401);
      pulse_start(2);
      feed(2, 1'b1, 1'b0);
      finish_run(2, "hs");

      pulse_start(0);
      finish_run(0, "zero");

      load_err_set();
      pulse_start(3);
      feed(3, 1'b0, 1'b1);
      finish_run(3, "midstart");

      load_err_set();
      ld(3, 1, 1, 5);
      ld(4, 2, 2, 9);
      pulse_start(5);
      feed(2, 1'b0, 1'b0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      check("mrst_rdy", 32'(in_ready), 32'd0);
      check("mrst_sum", sum_ed, 32'd0);
      check("mrst_cnt", 32'(err_cnt), 32'd0);
      check("mrst_max", 32'(max_ed), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_idle", 32'(busy), 32'd0);
      pulse_start(3);
      feed(3, 1'b0, 1'b0);
      finish_run(3, "rerun");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
